axis_capture_buffer: RTL and testbench

Single-clock capture buffer that sits directly downstream of one `mXX_axis` output of the AXIS channel switch. On a start pulse it records a programmed number of samples from the switch output, which has no back-pressure. It then replays them on a standard AXIS master with `tready`/`tlast` so that a DMA or packetizer can drain them at its own pace. It also counts samples that arrive while the buffer cannot accept them.

---
 rtl/axis_capture_buffer.sv | 193 +++++++++++++++++++
 tb/tb_axis_capture_buffer.sv | 376 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_capture_buffer.sv
// axis_capture_buffer: records a programmed burst from a switch output
// and replays it on an AXIS master. Drop counter enabled by AXIS_CAPTURE_DROPCNT_EN.
module axis_capture_buffer #(
   parameter int B = 8,
   parameter int N = 10
) (
   input  logic         aclk,
   input  logic         areset,
   input  logic         s_axis_tvalid,
   input  logic [B-1:0] s_axis_tdata,
   input  logic         start,
   input  logic [N-1:0] len,
   output logic         busy,
   output logic         done,
   output logic         m_axis_tvalid,
   input  logic         m_axis_tready,
   output logic [B-1:0] m_axis_tdata,
   output logic         m_axis_tlast,
   output logic [15:0]  drop_count
);

   typedef enum logic [1:0] {
      IDLE,
      CAPTURE,
      READOUT
   } state_t;

   localparam logic [N-1:0] ONE_N = N'(1);

   state_t state;
   state_t state_nx;

   logic [N-1:0] len_q;
   logic [N-1:0] wr_ptr;
   logic [N-1:0] rd_ptr;

   logic [B-1:0] mem [0:(1<<N)-1];
   logic [B-1:0] rd_data;
   logic         rd_vld;
   logic         rd_last;

   logic [B-1:0] out_data;
   logic         out_vld;
   logic         out_last;
   logic [B-1:0] skid_data;
   logic         skid_vld;
   logic         skid_last;

   logic         start_ok;
   logic         wr_en;
   logic         wr_done;
   logic         rd_en;
   logic         pop;
   logic         fin;
   logic [1:0]   occ;

   assign start_ok = (state == IDLE) && start;
   assign wr_en    = (state == CAPTURE) && s_axis_tvalid;
   assign wr_done  = wr_en && (wr_ptr == len_q - ONE_N);
   assign pop      = out_vld && m_axis_tready;
   assign fin      = pop && out_last;

   // beats held downstream or still in the RAM read pipeline
   assign occ = {1'b0, out_vld} + {1'b0, skid_vld} + {1'b0, rd_vld};

   // read only when the beat can land in the output register or the skid
   assign rd_en = (state == READOUT) && (rd_ptr != len_q)
                  && ((occ - {1'b0, pop}) <= 2'd1);

   // state register
   always_ff @(posedge aclk) begin
      if (areset) state <= IDLE;
      else        state <= state_nx;
   end

   // next-state decode
   always_comb begin
      state_nx = state;
      unique case (state)
         IDLE:    if (start && (len != '0)) state_nx = CAPTURE;
         CAPTURE: if (wr_done)              state_nx = READOUT;
         READOUT: if (fin)                  state_nx = IDLE;
         default:                           state_nx = IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy          = (state != IDLE);
      m_axis_tvalid = out_vld;
      m_axis_tdata  = out_data;
      m_axis_tlast  = out_vld && out_last;
   end

   // length latch, pointers and completion pulse
   always_ff @(posedge aclk) begin
      if (areset) begin
         len_q  <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         done   <= 1'b0;
      end else begin
         done <= (start_ok && (len == '0)) || fin;
         if (start_ok) begin
            len_q  <= len;
            wr_ptr <= '0;
            rd_ptr <= '0;
         end else begin
            if (wr_en) wr_ptr <= wr_ptr + ONE_N;
            if (rd_en) rd_ptr <= rd_ptr + ONE_N;
         end
      end
   end

   // sample RAM, one write port and one registered read port
   always_ff @(posedge aclk) begin
      if (wr_en) mem[wr_ptr] <= s_axis_tdata;
      if (rd_en) rd_data <= mem[rd_ptr];
   end

   // tracks which RAM read returns this cycle and whether it is the last
   always_ff @(posedge aclk) begin
      if (areset) begin
         rd_vld  <= 1'b0;
         rd_last <= 1'b0;
      end else begin
         rd_vld  <= rd_en;
         rd_last <= rd_en && (rd_ptr == len_q - ONE_N);
      end
   end

   // output register plus one-entry skid absorbing the RAM latency
   always_ff @(posedge aclk) begin
      if (areset) begin
         out_vld   <= 1'b0;
         out_last  <= 1'b0;
         out_data  <= '0;
         skid_vld  <= 1'b0;
         skid_last <= 1'b0;
         skid_data <= '0;
      end else begin
         if (!out_vld || pop) begin
            if (skid_vld) begin
               out_vld  <= 1'b1;
               out_data <= skid_data;
               out_last <= skid_last;
            end else begin
               out_vld <= rd_vld;
               if (rd_vld) begin
                  out_data <= rd_data;
                  out_last <= rd_last;
               end
            end
         end
         if (skid_vld) begin
            if (pop) begin
               skid_vld <= rd_vld;
               if (rd_vld) begin
                  skid_data <= rd_data;
                  skid_last <= rd_last;
               end
            end
         end else if (rd_vld && out_vld && !pop) begin
            skid_vld  <= 1'b1;
            skid_data <= rd_data;
            skid_last <= rd_last;
         end
      end
   end

`ifdef AXIS_CAPTURE_DROPCNT_EN
   logic [15:0] drop_q;
   logic        drop_hit;

   assign drop_hit = s_axis_tvalid
                     && (((state == IDLE) && !start) || (state == READOUT));

   // saturating count of samples arriving when the buffer cannot take them
   always_ff @(posedge aclk) begin
      if (areset)
         drop_q <= '0;
      else if (start_ok)
         drop_q <= '0;
      else if (drop_hit && (drop_q != 16'hFFFF))
         drop_q <= drop_q + 16'd1;
   end

   assign drop_count = drop_q;
`else
   assign drop_count = '0;
`endif

endmodule

// File: tb/tb_axis_capture_buffer.sv
// tb_axis_capture_buffer: randomized scenarios checked against a
// queue-based model of capture, replay and drop counting.
module tb_axis_capture_buffer;

   localparam int B = 8;
   localparam int N = 10;
   localparam int S_IDLE = 0;
   localparam int S_CAP  = 1;
   localparam int S_RO   = 2;

   logic         aclk = 1'b0;
   logic         areset;
   logic         s_axis_tvalid;
   logic [B-1:0] s_axis_tdata;
   logic         start;
   logic [N-1:0] len;
   logic         busy;
   logic         done;
   logic         m_axis_tvalid;
   logic         m_axis_tready;
   logic [B-1:0] m_axis_tdata;
   logic         m_axis_tlast;
   logic [15:0]  drop_count;

   int total = 0;
   int bad   = 0;

   int m_state;
   int m_len;
   int m_cap;
   int m_drop;
   int ro_cyc;
   bit exp_done;
   logic [B-1:0] exp_q[$];

   always #5 aclk = ~aclk;

   axis_capture_buffer #(.B(B), .N(N)) dut (
      .aclk          (aclk),
      .areset        (areset),
      .s_axis_tvalid (s_axis_tvalid),
      .s_axis_tdata  (s_axis_tdata),
      .start         (start),
      .len           (len),
      .busy          (busy),
      .done          (done),
      .m_axis_tvalid (m_axis_tvalid),
      .m_axis_tready (m_axis_tready),
      .m_axis_tdata  (m_axis_tdata),
      .m_axis_tlast  (m_axis_tlast),
      .drop_count    (drop_count)
   );

   function automatic logic [15:0] exp_drop();
`ifdef AXIS_CAPTURE_DROPCNT_EN
      return 16'(m_drop);
`else
      return 16'h0;
`endif
   endfunction

   task automatic model_clear();
      m_state  = S_IDLE;
      m_len    = 0;
      m_cap    = 0;
      m_drop   = 0;
      ro_cyc   = 0;
      exp_done = 1'b0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge aclk);
      areset = 1'b1;
      start = 1'b0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      @(negedge aclk);
      areset = 1'b0;
      model_clear();
   endtask

   task automatic test_reset();
      areset = 1'b1;
      start = 1'b0;
      len = '0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata = '0;
      m_axis_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge aclk);
         total++;
         if (busy !== 1'b0) begin
            bad++; $display("FAIL reset busy got=%b want=0", busy);
         end
         total++;
         if (done !== 1'b0) begin
            bad++; $display("FAIL reset done got=%b want=0", done);
         end
         total++;
         if (m_axis_tvalid !== 1'b0) begin
            bad++; $display("FAIL reset tvalid got=%b want=0", m_axis_tvalid);
         end
         total++;
         if (m_axis_tlast !== 1'b0) begin
            bad++; $display("FAIL reset tlast got=%b want=0", m_axis_tlast);
         end
         total++;
         if (m_axis_tdata !== '0) begin
            bad++; $display("FAIL reset tdata got=%h want=0", m_axis_tdata);
         end
         total++;
         if (drop_count !== 16'h0) begin
            bad++; $display("FAIL reset drop_count got=%0d want=0", drop_count);
         end
         start = 1'($urandom);
         len = N'($urandom);
         s_axis_tvalid = 1'($urandom);
         s_axis_tdata = B'($urandom);
         m_axis_tready = 1'($urandom);
      end
      areset = 1'b0;
      start = 1'b0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      model_clear();
   endtask

   // one capture/readout transaction; skip: already at an observation point
   task automatic run_capture(input string tag, input int n, input int vpct,
                              input int rpct, input int stall, input int base,
                              input bit poke, input bit skip, input int tail);
      bit fin = 1'b0;
      bit ok = 1'b0;
      int post = 0;
      int limit = 300 + n * 30;
      bit st, v, r, ev, hs, nd;
      logic [B-1:0] d;
      logic [N-1:0] ln;
      for (int cyc = 0; cyc < limit; cyc++) begin
         if (!(skip && cyc == 0)) begin
            @(negedge aclk);
            ev = (m_state == S_RO) && (ro_cyc >= 2);
            total++;
            if (busy !== (m_state != S_IDLE)) begin
               bad++;
               $display("FAIL %s busy cyc=%0d got=%b want=%b",
                        tag, cyc, busy, m_state != S_IDLE);
            end
            total++;
            if (done !== exp_done) begin
               bad++;
               $display("FAIL %s done cyc=%0d got=%b want=%b",
                        tag, cyc, done, exp_done);
            end
            total++;
            if (drop_count !== exp_drop()) begin
               bad++;
               $display("FAIL %s drop_count cyc=%0d got=%0d want=%0d",
                        tag, cyc, drop_count, exp_drop());
            end
            total++;
            if (m_axis_tvalid !== ev) begin
               bad++;
               $display("FAIL %s tvalid cyc=%0d got=%b want=%b",
                        tag, cyc, m_axis_tvalid, ev);
            end
            if (ev && m_axis_tvalid === 1'b1) begin
               total++;
               if (m_axis_tdata !== exp_q[0]) begin
                  bad++;
                  $display("FAIL %s tdata cyc=%0d got=%h want=%h",
                           tag, cyc, m_axis_tdata, exp_q[0]);
               end
               total++;
               if (m_axis_tlast !== (exp_q.size() == 1)) begin
                  bad++;
                  $display("FAIL %s tlast cyc=%0d got=%b want=%b",
                           tag, cyc, m_axis_tlast, exp_q.size() == 1);
               end
            end
            if (fin) begin
               post++;
               if (post == tail) begin
                  ok = 1'b1;
                  break;
               end
            end
         end else begin
            ev = 1'b0;
         end
         st = (cyc == 0);
         ln = (cyc == 0) ? n[N-1:0] : N'($urandom);
         if (poke && cyc > 0 && m_state != S_IDLE && $urandom_range(0, 7) == 0)
            st = 1'b1;
         if (m_state == S_CAP && base >= 0) begin
            v = 1'b1;
            d = B'(base + m_cap);
         end else begin
            v = ($urandom_range(1, 100) <= vpct);
            d = B'($urandom);
         end
         if (m_state == S_RO && ro_cyc < stall) r = 1'b0;
         else r = ($urandom_range(1, 100) <= rpct);
         start = st;
         len = ln;
         s_axis_tvalid = v;
         s_axis_tdata = d;
         m_axis_tready = r;
         hs = ev && r;
         nd = 1'b0;
         if (m_state == S_IDLE) begin
            if (st) begin
               m_len = int'(ln);
               m_drop = 0;
               m_cap = 0;
               exp_q.delete();
               if (ln == '0) nd = 1'b1;
               else m_state = S_CAP;
            end else if (v && m_drop < 65535) begin
               m_drop++;
            end
         end else if (m_state == S_CAP) begin
            if (v) begin
               exp_q.push_back(d);
               m_cap++;
               if (m_cap == m_len) begin
                  m_state = S_RO;
                  ro_cyc = 0;
               end
            end
         end else begin
            if (v && m_drop < 65535) m_drop++;
            ro_cyc++;
            if (hs) begin
               void'(exp_q.pop_front());
               if (exp_q.size() == 0) begin
                  m_state = S_IDLE;
                  nd = 1'b1;
               end
            end
         end
         exp_done = nd;
         if (nd) fin = 1'b1;
      end
      start = 1'b0;
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b0;
      if (!ok) begin
         total++;
         bad++;
         $display("FAIL %s timeout after %0d cycles", tag, limit);
         do_reset();
      end
   endtask

   task automatic test_basic();
      run_capture("basic", 8, 0, 100, 0, 'h10, 1'b0, 1'b0, 3);
   endtask

   task automatic test_backpressure();
      run_capture("backpressure", 16, 70, 50, 0, -1, 1'b0, 1'b0, 3);
   endtask

   task automatic test_drops();
      run_capture("drops", 4, 100, 100, 12, -1, 1'b0, 1'b0, 3);
   endtask

   task automatic test_len_zero();
      run_capture("len_zero", 0, 50, 100, 0, -1, 1'b0, 1'b0, 4);
   endtask

   task automatic test_len_max();
      run_capture("len_max", 1023, 80, 100, 0, -1, 1'b0, 1'b0, 3);
   endtask

   task automatic test_start_busy();
      run_capture("start_busy", 20, 60, 60, 0, -1, 1'b1, 1'b0, 3);
   endtask

   task automatic test_back_to_back();
      for (int k = 0; k < 5; k++)
         run_capture("back_to_back", $urandom_range(1, 40), 80, 70, 0, -1,
                     1'b1, k > 0, (k < 4) ? 1 : 3);
   endtask

   task automatic test_mid_reset();
      int hs_cnt = 0;
      bit hit = 1'b0;
      @(negedge aclk);
      start = 1'b1;
      len = N'(8);
      s_axis_tvalid = 1'b0;
      m_axis_tready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         @(negedge aclk);
         start = 1'b0;
         s_axis_tvalid = 1'b1;
         s_axis_tdata = B'(8'hA0 + i);
      end
      @(negedge aclk);
      s_axis_tvalid = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (m_axis_tvalid === 1'b1) begin
            total++;
            if (m_axis_tdata !== B'(8'hA0 + hs_cnt)) begin
               bad++;
               $display("FAIL mid_reset tdata beat=%0d got=%h want=%h",
                        hs_cnt, m_axis_tdata, B'(8'hA0 + hs_cnt));
            end
            if (hs_cnt == 5) begin
               areset = 1'b1;
               hit = 1'b1;
               break;
            end
            hs_cnt++;
         end
         @(negedge aclk);
      end
      if (!hit) begin
         total++;
         bad++;
         $display("FAIL mid_reset timeout beats=%0d want=5", hs_cnt);
         areset = 1'b1;
      end
      @(negedge aclk);
      areset = 1'b0;
      m_axis_tready = 1'b0;
      total++;
      if (m_axis_tvalid !== 1'b0) begin
         bad++; $display("FAIL mid_reset tvalid got=%b want=0", m_axis_tvalid);
      end
      total++;
      if (busy !== 1'b0) begin
         bad++; $display("FAIL mid_reset busy got=%b want=0", busy);
      end
      total++;
      if (m_axis_tdata !== '0) begin
         bad++; $display("FAIL mid_reset tdata got=%h want=0", m_axis_tdata);
      end
      total++;
      if (drop_count !== 16'h0) begin
         bad++; $display("FAIL mid_reset drop_count got=%0d want=0", drop_count);
      end
      for (int i = 0; i < 4; i++) begin
         total++;
         if (done !== 1'b0) begin
            bad++; $display("FAIL mid_reset done cyc=%0d got=%b want=0", i, done);
         end
         total++;
         if (m_axis_tvalid !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset idle cyc=%0d tvalid=%b busy=%b want=0",
                     i, m_axis_tvalid, busy);
         end
         @(negedge aclk);
      end
      model_clear();
      run_capture("after_reset", 3, 40, 80, 0, -1, 1'b0, 1'b0, 3);
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_drops();
      test_len_zero();
      test_len_max();
      test_start_busy();
      test_back_to_back();
      test_mid_reset();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
